// File: rtl/score_tracker.sv
// Score-check responder: looks up a player's personal best and the global best,
// reports personalwin/globalwin with a one-cycle valid pulse, and updates both records.
module score_tracker #(
  parameter int NUM_PLAYERS = 8,
  parameter int ID_W        = 3,
  parameter int SCORE_W     = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               score_req,
  input  logic [SCORE_W-1:0] score_in,
  input  logic [ID_W-1:0]    intPlayID_in,
  input  logic               isGuest_in,
  input  logic               clear_scores,
  output logic               valid,
  output logic               personalwin,
  output logic               globalwin,
  output logic               busy,
  output logic [SCORE_W-1:0] global_score,
  output logic [ID_W-1:0]    global_id,
  output logic               global_isGuest,
  output logic [1:0]         state_dbg
);

  // Handshake: score_req is a one-cycle pulse accepted only while busy=0; each accepted
  // request yields exactly one valid pulse two edges later, flags held until the next accept.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOOKUP  = 2'd1,
    COMPARE = 2'd2,
    RESPOND = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               guest_q, guest_d;
  logic [SCORE_W-1:0] pb_q, pb_d;
  logic [SCORE_W-1:0] gscore_q, gscore_d;
  logic [ID_W-1:0]    gid_q, gid_d;
  logic               gguest_q, gguest_d;
  logic               valid_q, valid_d;
  logic               pwin_q, pwin_d;
  logic               gwin_q, gwin_d;
  logic [SCORE_W-1:0] pb_tab_q [NUM_PLAYERS];
  logic [SCORE_W-1:0] pb_tab_d [NUM_PLAYERS];
  logic               pw, gw;

  // Strict unsigned compares: ties and zero scores never win.
  assign pw = !guest_q && (score_q > pb_q);
  assign gw = score_q > gscore_q;

  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    id_d     = id_q;
    guest_d  = guest_q;
    pb_d     = pb_q;
    gscore_d = gscore_q;
    gid_d    = gid_q;
    gguest_d = gguest_q;
    valid_d  = valid_q;
    pwin_d   = pwin_q;
    gwin_d   = gwin_q;
    pb_tab_d = pb_tab_q;
    case (state_q)
      IDLE: begin
        if (score_req) begin
          score_d = score_in;
          id_d    = intPlayID_in;
          guest_d = isGuest_in;
          pwin_d  = 1'b0;
          gwin_d  = 1'b0;
          state_d = LOOKUP;
        end else if (clear_scores) begin
          for (int i = 0; i < NUM_PLAYERS; i++) pb_tab_d[i] = '0;
          gscore_d = '0;
          gid_d    = '0;
          gguest_d = 1'b0;
        end
      end
      LOOKUP: begin
        // Guests never touch the personal table.
        pb_d    = guest_q ? '0 : pb_tab_q[id_q];
        state_d = COMPARE;
      end
      COMPARE: begin
        pwin_d  = pw;
        gwin_d  = gw;
        valid_d = 1'b1;
        if (pw) pb_tab_d[id_q] = score_q;
        if (gw) begin
          gscore_d = score_q;
          gid_d    = id_q;
          gguest_d = guest_q;
        end
        state_d = RESPOND;
      end
      RESPOND: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      score_q  <= '0;
      id_q     <= '0;
      guest_q  <= 1'b0;
      pb_q     <= '0;
      gscore_q <= '0;
      gid_q    <= '0;
      gguest_q <= 1'b0;
      valid_q  <= 1'b0;
      pwin_q   <= 1'b0;
      gwin_q   <= 1'b0;
      for (int i = 0; i < NUM_PLAYERS; i++) pb_tab_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      score_q  <= score_d;
      id_q     <= id_d;
      guest_q  <= guest_d;
      pb_q     <= pb_d;
      gscore_q <= gscore_d;
      gid_q    <= gid_d;
      gguest_q <= gguest_d;
      valid_q  <= valid_d;
      pwin_q   <= pwin_d;
      gwin_q   <= gwin_d;
      for (int i = 0; i < NUM_PLAYERS; i++) pb_tab_q[i] <= pb_tab_d[i];
    end
  end

  assign valid          = valid_q;
  assign personalwin    = pwin_q;
  assign globalwin      = gwin_q;
  assign busy           = (state_q != IDLE);
  assign global_score   = gscore_q;
  assign global_id      = gid_q;
  assign global_isGuest = gguest_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_score_tracker.sv
// Self-checking bench for score_tracker: directed scenarios plus randomized requests
// compared against a table-based reference model of the scoring rules.
module tb_score_tracker;
  localparam int NUM_PLAYERS = 8;
  localparam int ID_W        = 3;
  localparam int SCORE_W     = 7;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               score_req = 1'b0;
  logic [SCORE_W-1:0] score_in = '0;
  logic [ID_W-1:0]    intPlayID_in = '0;
  logic               isGuest_in = 1'b0;
  logic               clear_scores = 1'b0;
  logic               valid, personalwin, globalwin, busy, global_isGuest;
  logic [SCORE_W-1:0] global_score;
  logic [ID_W-1:0]    global_id;
  logic [1:0]         state_dbg;

  int checks = 0;
  int errors = 0;

  // Reference model: personal bests per player plus the global record.
  int model_pb [NUM_PLAYERS];
  int model_gs;
  int model_gid;
  bit model_gg;
  bit model_pw;
  bit model_gw;

  score_tracker #(.NUM_PLAYERS(NUM_PLAYERS), .ID_W(ID_W), .SCORE_W(SCORE_W)) dut (
    .clk(clk), .rst(rst), .score_req(score_req), .score_in(score_in),
    .intPlayID_in(intPlayID_in), .isGuest_in(isGuest_in), .clear_scores(clear_scores),
    .valid(valid), .personalwin(personalwin), .globalwin(globalwin), .busy(busy),
    .global_score(global_score), .global_id(global_id), .global_isGuest(global_isGuest),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < NUM_PLAYERS; i++) model_pb[i] = 0;
    model_gs = 0;
    model_gid = 0;
    model_gg = 1'b0;
  endtask

  // One accepted request with cycle-accurate checks of the response window.
  task automatic run_req(input int score, input int id, input bit guest, input bit with_clear);
    bit exp_pw, exp_gw;
    exp_pw = !guest && (score > model_pb[id]);
    exp_gw = score > model_gs;
    @(negedge clk);
    score_req = 1'b1;
    score_in = SCORE_W'(score);
    intPlayID_in = ID_W'(id);
    isGuest_in = guest;
    clear_scores = with_clear;
    @(negedge clk);
    score_req = 1'b0;
    clear_scores = 1'b0;
    score_in = SCORE_W'($urandom_range(0, 127));
    intPlayID_in = ID_W'($urandom_range(0, 7));
    isGuest_in = 1'($urandom_range(0, 1));
    checks++;
    if (busy !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL accept_e0: busy=%b valid=%b, required busy=1 valid=0", busy, valid);
    end
    @(negedge clk);
    checks++;
    if (valid !== 1'b0) begin
      errors++;
      $display("FAIL early_valid: valid=%b at E0+1, required 0", valid);
    end
    @(negedge clk);
    if (exp_pw) model_pb[id] = score;
    if (exp_gw) begin
      model_gs = score;
      model_gid = id;
      model_gg = guest;
    end
    model_pw = exp_pw;
    model_gw = exp_gw;
    checks++;
    if (valid !== 1'b1 || personalwin !== exp_pw || globalwin !== exp_gw) begin
      errors++;
      $display("FAIL response(s=%0d id=%0d g=%0b): valid=%b pw=%b gw=%b, required 1 %b %b",
               score, id, guest, valid, personalwin, globalwin, exp_pw, exp_gw);
    end
    checks++;
    if (global_score !== SCORE_W'(model_gs) || global_id !== ID_W'(model_gid) ||
        global_isGuest !== model_gg) begin
      errors++;
      $display("FAIL global_rec: %0d/%0d/%b, required %0d/%0d/%b",
               global_score, global_id, global_isGuest, model_gs, model_gid, model_gg);
    end
    @(negedge clk);
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || personalwin !== exp_pw || globalwin !== exp_gw) begin
      errors++;
      $display("FAIL after_valid: valid=%b busy=%b pw=%b gw=%b, required 0 0 %b %b",
               valid, busy, personalwin, globalwin, exp_pw, exp_gw);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    checks++;
    if (valid !== 1'b0 || personalwin !== 1'b0 || globalwin !== 1'b0 || busy !== 1'b0 ||
        global_score !== '0 || global_id !== '0 || global_isGuest !== 1'b0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: v=%b pw=%b gw=%b busy=%b gs=%0d gid=%0d gg=%b st=%0d, required all 0",
               valid, personalwin, globalwin, busy, global_score, global_id, global_isGuest, state_dbg);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_req(25, 2, 1'b0, 1'b0);
    checks++;
    if (personalwin !== 1'b1 || globalwin !== 1'b1 || global_score !== 7'd25 || global_id !== 3'd2) begin
      errors++;
      $display("FAIL first_win: pw=%b gw=%b gs=%0d gid=%0d, required 1 1 25 2",
               personalwin, globalwin, global_score, global_id);
    end
    run_req(25, 2, 1'b0, 1'b0);
    checks++;
    if (personalwin !== 1'b0 || globalwin !== 1'b0) begin
      errors++;
      $display("FAIL tie: pw=%b gw=%b, required 0 0", personalwin, globalwin);
    end
    run_req(10, 5, 1'b0, 1'b0);
    checks++;
    if (personalwin !== 1'b1 || globalwin !== 1'b0 || global_score !== 7'd25) begin
      errors++;
      $display("FAIL personal_only: pw=%b gw=%b gs=%0d, required 1 0 25", personalwin, globalwin, global_score);
    end
  endtask

  task automatic test_guest();
    run_req(90, 0, 1'b1, 1'b0);
    checks++;
    if (personalwin !== 1'b0 || globalwin !== 1'b1 || global_isGuest !== 1'b1 || global_id !== 3'd0) begin
      errors++;
      $display("FAIL guest_global: pw=%b gw=%b gg=%b gid=%0d, required 0 1 1 0",
               personalwin, globalwin, global_isGuest, global_id);
    end
    run_req(5, 0, 1'b0, 1'b0);
    checks++;
    if (personalwin !== 1'b1 || globalwin !== 1'b0) begin
      errors++;
      $display("FAIL guest_no_pb_write: pw=%b gw=%b, required 1 0", personalwin, globalwin);
    end
  endtask

  // A second request and a clear arriving while busy must both be dropped.
  task automatic test_ignore_busy();
    int vcount;
    vcount = 0;
    @(negedge clk);
    score_req = 1'b1;
    score_in = 7'd3;
    intPlayID_in = 3'd6;
    isGuest_in = 1'b0;
    @(negedge clk);
    score_req = 1'b1;
    score_in = 7'd127;
    intPlayID_in = 3'd7;
    clear_scores = 1'b1;
    @(negedge clk);
    score_req = 1'b0;
    clear_scores = 1'b1;
    if (valid === 1'b1) vcount++;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      clear_scores = 1'b0;
      if (valid === 1'b1) vcount++;
    end
    model_pb[6] = 3;
    checks++;
    if (vcount !== 1) begin
      errors++;
      $display("FAIL busy_ignore_count: %0d valid pulses, required 1", vcount);
    end
    checks++;
    if (personalwin !== 1'b1 || globalwin !== 1'b0 || global_score !== SCORE_W'(model_gs)) begin
      errors++;
      $display("FAIL busy_ignore_result: pw=%b gw=%b gs=%0d, required 1 0 %0d",
               personalwin, globalwin, global_score, model_gs);
    end
  endtask

  task automatic test_clear();
    @(negedge clk);
    clear_scores = 1'b1;
    @(negedge clk);
    clear_scores = 1'b0;
    model_clear();
    checks++;
    if (global_score !== '0 || global_id !== '0 || global_isGuest !== 1'b0) begin
      errors++;
      $display("FAIL clear_global: %0d/%0d/%b, required 0/0/0", global_score, global_id, global_isGuest);
    end
    run_req(1, 2, 1'b0, 1'b0);
    checks++;
    if (personalwin !== 1'b1 || globalwin !== 1'b1) begin
      errors++;
      $display("FAIL clear_then_req: pw=%b gw=%b, required 1 1", personalwin, globalwin);
    end
    // Request beside a clear: the clear is dropped, so a tie must not win.
    run_req(1, 2, 1'b0, 1'b1);
  endtask

  task automatic test_reset_midflight();
    int vcount;
    vcount = 0;
    run_req(60, 3, 1'b0, 1'b0);
    @(negedge clk);
    score_req = 1'b1;
    score_in = 7'd100;
    intPlayID_in = 3'd4;
    isGuest_in = 1'b0;
    @(negedge clk);
    score_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || global_score !== '0 || personalwin !== 1'b0 || globalwin !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_compare: v=%b busy=%b gs=%0d pw=%b gw=%b, required all 0",
               valid, busy, global_score, personalwin, globalwin);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (valid === 1'b1) vcount++;
    end
    rst = 1'b1;
    model_clear();
    checks++;
    if (vcount !== 0) begin
      errors++;
      $display("FAIL reset_abort_valid: %0d pulses, required 0", vcount);
    end
    run_req(0, 3, 1'b0, 1'b0);
    run_req(1, 3, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    int score, id, gap;
    bit guest, wclr;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) begin
        @(negedge clk);
        clear_scores = 1'b1;
        @(negedge clk);
        clear_scores = 1'b0;
        model_clear();
      end
      score = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 12);
      id = $urandom_range(0, NUM_PLAYERS - 1);
      guest = ($urandom_range(0, 3) == 0);
      wclr = ($urandom_range(0, 7) == 0);
      run_req(score, id, guest, wclr);
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_guest();
    test_ignore_busy();
    test_clear();
    test_reset_midflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
